pipe_scroller: RTL and testbench
================================

// Module: pipe_scroller
// PURPOSE
//  Generates and scrolls the Flappy Bird pipe field for the LED matrix.
//  On each scroll tick the whole field shifts one column; every SPACING ticks a new pipe column is
//  injected at column 0, with its gap row chosen by an internal LFSR.
//  Sits between the game-speed tick divider and the matrix driver/collision checker.
//  Supersedes the fixed 16x16, 4-pattern combinational pipe lookup.
// PARAMETERS
//  ROWS     16     matrix rows; power of two, >= 8
//  COLS     16     matrix columns, >= 2
//  GAP      4      gap height in rows; 1 <= GAP <= ROWS/2
//  SPACING  8      ticks between injected pipes (>= 2)
//  BIRD_COL 13     column the bird occupies; 1 <= BIRD_COL <= COLS-1
//  SEED     8'h01  LFSR reset value; 0 is replaced by 8'h01
// PORTS
//  clk        in   1            system clock
//  reset_n    in   1            synchronous active-low reset
//  start      in   1            level/pulse: begin or restart a run
//  halt       in   1            freeze field (collision / pause)
//  tick       in   1            one-cycle scroll strobe
//  field      out  [ROWS][COLS] field[r][c]=1 -> pipe lit; bit 0 = entry column
//  running    out  1            high in RUN state
//  pass_pulse out  1            one-cycle pulse when a pipe column reaches BIRD_COL
//  last_gap   out  clog2(ROWS)  top row of the gap of the most recently injected pipe
// BEHAVIOUR
//  Reset (reset_n=0 at posedge clk): state=IDLE, field=0, running=0, pass_pulse=0, last_gap=0,
//   spc_cnt=0, lfsr=SEED.
//  FSM: IDLE --start--> RUN; RUN --halt--> FROZEN; FROZEN --start (halt low)--> RUN.
//   Any transition into RUN clears field and loads spc_cnt=SPACING-1. lfsr is not reseeded.
//  Priority: reset > halt > start > tick.
//   Tick is ignored in IDLE and FROZEN, and in the cycle start or halt is asserted.
//  Accepted tick (RUN, no halt/start):
//   - field[r] <= {field[r][COLS-2:0], inj[r]}; the result is visible in the next cycle.
//   - spc_cnt != 0: inj = 0 and spc_cnt decrements.
//   - spc_cnt == 0: inj = pipe column and spc_cnt <= SPACING-1.
//  Pipe column: cand = lfsr[clog2(ROWS)-1:0].
//   - g = cand if cand <= ROWS-GAP, else cand-(ROWS-GAP+1).
//   - inj[r] = 0 for g <= r < g+GAP, else 1.
//   - last_gap <= g, and lfsr advances once.
//  LFSR: 8-bit Galois, right shift, taps 8'hB8: next = lfsr[0] ? (lfsr>>1)^8'hB8 : lfsr>>1.
//   It advances only on injection.
//  pass_pulse <= accepted tick && |field[*][BIRD_COL-1] (pre-shift value); 0 otherwise.
//  Columns shifted out of bit COLS-1 are discarded. Field is held in IDLE-exit wait and FROZEN.
//  running = (state==RUN), registered with the state.
// STRUCTURE
//  Package pipe_pkg holds:
//   - state enum {IDLE, RUN, FROZEN};
//   - LFSR_TAPS = 8'hB8;
//   - ROWS/COLS defaults;
//   - typedef for the field array.
//  Sub-module pipe_lfsr (8-bit Galois: clk, reset_n, advance, seed -> value).
//  Top holds the FSM, spc_cnt, gap mapping, shift register and pass detect.
// TESTING (ROWS=16, COLS=16, GAP=4, SPACING=8, BIRD_COL=13, SEED=8'h01)
//  1. Reset, then start, then 8 ticks -> ticks 1-7 give field=0.
//     After tick 8: column 0 = 1 except rows 1..4, last_gap=1.
//  2. Continue to 24 ticks -> the next gaps are 8 and 12.
//     The 4th pipe has gap 1 (cand 14 wrapped to 1).
//  3. Pipe injected at tick 8 -> pass_pulse high exactly once, in the cycle after tick 21.
//  4. halt with tick in the same cycle -> no shift, state FROZEN, running=0.
//     Further ticks leave field unchanged.
//  5. start in FROZEN -> field=0, running=1.
//     The next pipe appears after 8 ticks, with gap taken from the continued LFSR (no reseed).
//  6. reset_n low mid-run with tick high -> next cycle all outputs 0, IDLE, lfsr=01.
//     Ticks are ignored until start.

Source files
------------

// File: rtl/pipe_scroller_pkg.sv
// Shared types and constants for the scrolling pipe field: FSM states, LFSR taps,
// default matrix geometry and the Galois LFSR step function.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int ROWS_DEF = 16;
  localparam int COLS_DEF = 16;

  typedef logic [ROWS_DEF-1:0][COLS_DEF-1:0] field_t;

  // Right-shifting Galois step: the bit falling off the bottom folds the taps back in.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    logic [7:0] shifted;
    shifted = {1'b0, v[7:1]};
    if (v[0]) begin
      lfsr_next = shifted ^ LFSR_TAPS;
    end else begin
      lfsr_next = shifted;
    end
  endfunction

endpackage

// File: rtl/pipe_scroller_if.sv
// Control strobes in, pipe field and status out, between the tick divider and the
// matrix driver / collision checker.
interface pipe_scroller_if import pipe_pkg::*; #(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
);
  localparam int RB = $clog2(ROWS);

  logic                       start;
  logic                       halt;
  logic                       tick;
  logic [ROWS-1:0][COLS-1:0]  field;
  logic                       running;
  logic                       pass_pulse;
  logic [RB-1:0]              last_gap;

  modport master (
    output start, halt, tick,
    input  field, running, pass_pulse, last_gap
  );

  modport slave (
    input  start, halt, tick,
    output field, running, pass_pulse, last_gap
  );
endinterface

// File: rtl/pipe_scroller_lfsr.sv
// 8-bit Galois LFSR that supplies pipe gap positions; it steps only when asked,
// so the gap sequence is tied to injections rather than to time.
module pipe_lfsr import pipe_pkg::*; (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       advance,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] r_value;

  // LFSR state: reloads the seed on reset, otherwise steps on request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_value <= seed;
    end else if (advance) begin
      r_value <= lfsr_next(r_value);
    end else begin
      r_value <= r_value;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/pipe_scroller.sv
// Scrolling Flappy Bird pipe field: shifts one column per accepted tick and injects
// a new pipe column with an LFSR-chosen gap every SPACING ticks.
module pipe_scroller import pipe_pkg::*; #(
  parameter int         ROWS     = ROWS_DEF,
  parameter int         COLS     = COLS_DEF,
  parameter int         GAP      = 4,
  parameter int         SPACING  = 8,
  parameter int         BIRD_COL = 13,
  parameter logic [7:0] SEED     = 8'h01
) (
  input  logic             clk,
  input  logic             reset_n,
  pipe_scroller_if.slave   bus
);

  localparam int         RB       = $clog2(ROWS);
  localparam int         CW       = RB + 1;
  localparam int         SB       = $clog2(SPACING);
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [CW-1:0] GAP_MAX  = CW'(ROWS - GAP);
  localparam logic [CW-1:0] GAP_WRAP = CW'(ROWS - GAP + 1);
  localparam logic [SB-1:0] SPC_LOAD = SB'(SPACING - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_running;
  logic [ROWS-1:0][COLS-1:0] r_field;
  logic [SB-1:0]             r_spc_cnt;
  logic                      r_pass;
  logic [RB-1:0]             r_last_gap;

  logic                      w_restart;
  logic                      w_accept;
  logic                      w_inject;
  logic [7:0]                w_lfsr;
  logic [CW-1:0]             w_cand;
  logic [CW-1:0]             w_wrapped;
  logic [RB-1:0]             w_gap;
  logic [ROWS-1:0]           w_inj;
  logic                      w_bird_hit;
  logic                      w_unused_lfsr;

  pipe_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (w_inject),
    .seed    (SEED_EFF),
    .value   (w_lfsr)
  );

  // State register; running is registered alongside so it tracks the state exactly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
    end
  end

  // Next state: halt outranks start, and start only re-enters RUN while halt is low.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start && !bus.halt) w_state_nxt = RUN;
        else                        w_state_nxt = IDLE;
      end
      RUN: begin
        if (bus.halt) w_state_nxt = FROZEN;
        else          w_state_nxt = RUN;
      end
      FROZEN: begin
        if (bus.start && !bus.halt) w_state_nxt = RUN;
        else                        w_state_nxt = FROZEN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath controls: a start that lands in RUN restarts the field; ticks lose to start/halt.
  always_comb begin
    w_restart = bus.start && !bus.halt && (w_state_nxt == RUN);
    w_accept  = (r_state == RUN) && bus.tick && !bus.halt && !bus.start;
    if (w_accept && (r_spc_cnt == {SB{1'b0}})) begin
      w_inject = 1'b1;
    end else begin
      w_inject = 1'b0;
    end
  end

  // Gap placement: out-of-range candidates wrap back into the legal top-row range.
  always_comb begin
    w_cand    = {1'b0, w_lfsr[RB-1:0]};
    w_wrapped = w_cand - GAP_WRAP;
    if (w_cand <= GAP_MAX) begin
      w_gap = w_cand[RB-1:0];
    end else begin
      w_gap = w_wrapped[RB-1:0];
    end
    w_inj = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (w_inject && !((r >= int'(w_gap)) && (r < int'(w_gap) + GAP))) begin
        w_inj[r] = 1'b1;
      end else begin
        w_inj[r] = 1'b0;
      end
    end
  end

  assign w_unused_lfsr = ^w_lfsr[7:RB];

  // A pipe is "passing" when the column just before the bird is lit before the shift.
  always_comb begin
    w_bird_hit = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      w_bird_hit = w_bird_hit | r_field[r][BIRD_COL-1];
    end
  end

  // Field shift register: column 0 takes the injected column, the far column drops off.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_field <= '0;
    end else if (w_restart) begin
      r_field <= '0;
    end else if (w_accept) begin
      for (int r = 0; r < ROWS; r++) begin
        r_field[r] <= {r_field[r][COLS-2:0], w_inj[r]};
      end
    end else begin
      r_field <= r_field;
    end
  end

  // Spacing counter: counts down accepted ticks and reloads on each injection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_spc_cnt <= {SB{1'b0}};
    end else if (w_restart) begin
      r_spc_cnt <= SPC_LOAD;
    end else if (w_inject) begin
      r_spc_cnt <= SPC_LOAD;
    end else if (w_accept) begin
      r_spc_cnt <= r_spc_cnt - SB'(1);
    end else begin
      r_spc_cnt <= r_spc_cnt;
    end
  end

  // Pass strobe and last injected gap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pass     <= 1'b0;
      r_last_gap <= {RB{1'b0}};
    end else begin
      r_pass <= w_accept && w_bird_hit;
      if (w_inject) begin
        r_last_gap <= w_gap;
      end else begin
        r_last_gap <= r_last_gap;
      end
    end
  end

  assign bus.field      = r_field;
  assign bus.running    = r_running;
  assign bus.pass_pulse = r_pass;
  assign bus.last_gap   = r_last_gap;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: a reference model pushes expected outputs for each
// driven cycle into a queue, which is popped and compared after the clock edge.
module tb_pipe_scroller;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pipe_scroller_if #(.ROWS(16), .COLS(16)) bus ();

  pipe_scroller #(
    .ROWS(16), .COLS(16), .GAP(4), .SPACING(8), .BIRD_COL(13), .SEED(8'h01)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    field_t     field;
    logic       running;
    logic       pass;
    logic [3:0] gap;
  } exp_t;

  exp_t   sb[$];
  state_t m_state;
  field_t m_field;
  int     m_cnt;
  logic [7:0] m_lfsr;
  logic [3:0] m_gap;
  logic   m_pass;
  int     n_pass  = 0;
  int     n_total = 0;
  int     pulses;
  field_t snap;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] col_of(input field_t f, input int c);
    logic [15:0] v;
    for (int r = 0; r < 16; r++) v[r] = f[r][c];
    return v;
  endfunction

  task automatic model_cycle(input logic rn, input logic s, input logic h, input logic t);
    logic acc;
    logic hit;
    logic [15:0] col;
    int cand;
    int g;
    exp_t e;
    if (!rn) begin
      m_state = IDLE; m_field = '0; m_cnt = 0; m_lfsr = 8'h01; m_gap = 4'd0; m_pass = 1'b0;
    end else begin
      acc = (m_state == RUN) && t && !h && !s;
      hit = |col_of(m_field, 12);
      m_pass = acc && hit;
      if (h) begin
        if (m_state == RUN) m_state = FROZEN;
      end else if (s) begin
        m_state = RUN; m_field = '0; m_cnt = 7;
      end else if (acc) begin
        col = 16'h0000;
        if (m_cnt == 0) begin
          cand = int'(m_lfsr[3:0]);
          g = (cand <= 12) ? cand : cand - 13;
          for (int r = 0; r < 16; r++) col[r] = !((r >= g) && (r < g + 4));
          m_gap = 4'(g);
          m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
          m_cnt = 7;
        end else begin
          m_cnt = m_cnt - 1;
        end
        for (int r = 0; r < 16; r++) m_field[r] = {m_field[r][14:0], col[r]};
      end
    end
    e.field = m_field; e.running = (m_state == RUN); e.pass = m_pass; e.gap = m_gap;
    sb.push_back(e);
  endtask

  task automatic step(input logic rn, input logic s, input logic h, input logic t);
    exp_t e;
    reset_n = rn; bus.start = s; bus.halt = h; bus.tick = t;
    model_cycle(rn, s, h, t);
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.halt = 1'b0; bus.tick = 1'b0; reset_n = 1'b1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 256'd0, 256'd1);
    end else begin
      e = sb.pop_front();
      check("field", bus.field, e.field);
      check("running", {255'd0, bus.running}, {255'd0, e.running});
      check("pass_pulse", {255'd0, bus.pass_pulse}, {255'd0, e.pass});
      check("last_gap", {252'd0, bus.last_gap}, {252'd0, e.gap});
    end
  endtask

  initial begin
    reset_n = 1'b0; bus.start = 1'b0; bus.halt = 1'b0; bus.tick = 1'b0;
    @(posedge clk); #1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_field", bus.field, 256'd0);
    check("reset_running", {255'd0, bus.running}, 256'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("idle_tick_ignored", bus.field, 256'd0);

    // Run: four pipes with gaps 1, 8, 12, 1; first pipe passes the bird after tick 21.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("start_running", {255'd0, bus.running}, 256'd1);
    pulses = 0;
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      if (i <= 21 && bus.pass_pulse === 1'b1) pulses++;
      if (i < 8)  check("early_field_zero", bus.field, 256'd0);
      if (i == 8) begin
        check("t8_col0", {240'd0, col_of(bus.field, 0)}, {240'd0, 16'hFFE1});
        check("t8_gap", {252'd0, bus.last_gap}, 256'd1);
      end
      if (i == 16) check("t16_gap", {252'd0, bus.last_gap}, 256'd8);
      if (i == 21) check("t21_pass", {255'd0, bus.pass_pulse}, 256'd1);
      if (i == 24) check("t24_gap", {252'd0, bus.last_gap}, 256'd12);
      if (i == 32) check("t32_gap_wrap", {252'd0, bus.last_gap}, 256'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (i <= 21 && bus.pass_pulse === 1'b1) pulses++;
    end
    check("pass_count", pulses, 256'd1);

    // Halt with a coincident tick freezes without shifting.
    snap = bus.field;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("halt_no_shift", bus.field, snap);
    check("halt_running", {255'd0, bus.running}, 256'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check("frozen_hold", bus.field, snap);

    // Restart from FROZEN: cleared field, LFSR continues (0x17 -> gap 7).
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("restart_field", bus.field, 256'd0);
    check("restart_running", {255'd0, bus.running}, 256'd1);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check("resume_gap", {252'd0, bus.last_gap}, 256'd7);
    check("resume_col0", {240'd0, col_of(bus.field, 0)}, {240'd0, 16'hF87F});
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-run with tick high, then ticks ignored until start; LFSR reseeded.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_field", bus.field, 256'd0);
    check("rst_running", {255'd0, bus.running}, 256'd0);
    check("rst_gap", {252'd0, bus.last_gap}, 256'd0);
    check("rst_pass", {255'd0, bus.pass_pulse}, 256'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_idle_ticks", bus.field, 256'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check("reseed_gap", {252'd0, bus.last_gap}, 256'd1);

    check("scoreboard_drained", sb.size(), 256'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
